// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: write-port arbiter for the integer register file.
//
// Two writeback sources share one register-file write port:
//   req0 - main pipeline writeback (normal priority)
//   req1 - long-latency unit (load/CSR/multi-cycle); it gains priority after
//          MAX_WAIT consecutive stalled cycles, so it cannot be starved.
// Writes to x0 are accepted at once and never use the port.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   i_valid0/i_addr0/i_data0  req0 write request
//   o_ready0                  req0 accepted this cycle (combinational)
//   i_valid1/i_addr1/i_data1  req1 write request
//   o_ready1                  req1 accepted this cycle (combinational)
//   o_wen_rf/o_waddr/o_wdata  registered write command to the register file
//   o_boost                   req1 currently holds priority (combinational)
//   o_conflicts               saturating count of cycles with both requests live
module rf_wb_arbiter #(
  parameter int unsigned A_WIDTH   = 5,
  parameter int unsigned D_WIDTH   = 32,
  parameter int unsigned MAX_WAIT  = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid0,
  input  logic [A_WIDTH-1:0]   i_addr0,
  input  logic [D_WIDTH-1:0]   i_data0,
  output logic                 o_ready0,
  input  logic                 i_valid1,
  input  logic [A_WIDTH-1:0]   i_addr1,
  input  logic [D_WIDTH-1:0]   i_data1,
  output logic                 o_ready1,
  output logic                 o_wen_rf,
  output logic [A_WIDTH-1:0]   o_waddr,
  output logic [D_WIDTH-1:0]   o_wdata,
  output logic                 o_boost,
  output logic [CNT_WIDTH-1:0] o_conflicts
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_WIDTH-1:0] conflicts_d;
  logic eff0, eff1, grant0, grant1;

  always_comb begin
    eff0 = i_valid0 && (i_addr0 != '0);
    eff1 = i_valid1 && (i_addr1 != '0);

    o_boost = (wait_cnt_q == MaxWait);

    // req1 wins when alone or when boosted; req0 wins otherwise.
    grant1 = eff1 && (!eff0 || o_boost);
    grant0 = eff0 && (!eff1 || !o_boost);

    // x0 writes are acknowledged without touching the port.
    o_ready0 = grant0 || (i_valid0 && (i_addr0 == '0));
    o_ready1 = grant1 || (i_valid1 && (i_addr1 == '0));

    wait_cnt_d = '0;
    if (eff1 && !grant1) begin
      wait_cnt_d = (wait_cnt_q == MaxWait) ? wait_cnt_q : wait_cnt_q + 4'd1;
    end

    conflicts_d = o_conflicts;
    if (eff0 && eff1 && !(&o_conflicts)) begin
      conflicts_d = o_conflicts + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_q  <= '0;
      o_conflicts <= '0;
      o_wen_rf    <= 1'b0;
      o_waddr     <= '0;
      o_wdata     <= '0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      o_conflicts <= conflicts_d;
      o_wen_rf    <= grant0 || grant1;
      // Address/data hold their last value when nothing is granted.
      if (grant1) begin
        o_waddr <= i_addr1;
        o_wdata <= i_data1;
      end else if (grant0) begin
        o_waddr <= i_addr0;
        o_wdata <= i_data0;
      end
    end
  end

endmodule
